// File: rtl/ro_mux_seq_if.sv
// Bus between the ring-oscillator mux sequencer and its controller.
// The controller drives the requests; the mux drives the gated output and status.
interface ro_mux_seq_if #(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
);
  logic [N_CH-1:0]  ro_in;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             sel_load;
  logic             start;
  logic             stop;
  logic             ro_out;
  logic [SEL_W-1:0] cur_sel;
  logic             valid;
  logic             window_done;
  logic             scan_done;
  logic             busy;

  modport master (
    output ro_in, mode, sel_in, sel_load, start, stop,
    input  ro_out, cur_sel, valid, window_done, scan_done, busy
  );

  modport slave (
    input  ro_in, mode, sel_in, sel_load, start, stop,
    output ro_out, cur_sel, valid, window_done, scan_done, busy
  );
endinterface

// File: rtl/ro_mux_seq.sv
// Ring-oscillator channel mux: manual select or timed scan over all channels,
// gating the selected oscillator off for a settle period after every select change.
module ro_mux_seq #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int SETTLE = 4,
  parameter int DWELL  = 1024
) (
  input logic         clk,
  input logic         rst_n,
  ro_mux_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE} st_t;

  localparam logic [7:0]       SET_LAST = 8'(SETTLE - 1);
  localparam logic [15:0]      DW_LAST  = 16'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  st_t              st, st_n;
  logic [SEL_W-1:0] cur_sel, sel_n;
  logic             mode_q, modeq_n;
  logic [7:0]       scnt, scnt_n;
  logic [15:0]      dcnt, dcnt_n;
  logic             valid, wdone, sdone, busy;
  logic             wd_n, sd_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cur_sel <= '0;
      mode_q  <= 1'b0;
      scnt    <= '0;
      dcnt    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      wdone   <= 1'b0;
      sdone   <= 1'b0;
    end else begin
      st      <= st_n;
      cur_sel <= sel_n;
      mode_q  <= modeq_n;
      scnt    <= scnt_n;
      dcnt    <= dcnt_n;
      valid   <= (st_n == S_MEASURE);
      busy    <= (st_n != S_IDLE);
      wdone   <= wd_n;
      sdone   <= sd_n;
    end
  end

  always_comb begin
    st_n    = st;
    sel_n   = cur_sel;
    modeq_n = mode_q;
    scnt_n  = scnt;
    dcnt_n  = dcnt;
    wd_n    = 1'b0;
    sd_n    = 1'b0;
    case (st)
      S_IDLE: begin
        // stop in IDLE swallows any simultaneous load/start
        if (!bus.stop) begin
          if (!bus.mode && bus.sel_load) begin
            sel_n   = bus.sel_in;
            modeq_n = 1'b0;
            scnt_n  = '0;
            st_n    = S_SETTLE;
          end else if (bus.mode && bus.start) begin
            sel_n   = '0;
            modeq_n = 1'b1;
            scnt_n  = '0;
            st_n    = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (scnt == SET_LAST) begin
          dcnt_n = '0;
          st_n   = S_MEASURE;
        end else begin
          scnt_n = scnt + 8'd1;
        end
      end
      S_MEASURE: begin
        if (bus.stop) begin
          st_n = S_IDLE;
        end else if (!mode_q) begin
          // a reload always re-settles, even onto the same channel
          if (bus.sel_load) begin
            sel_n  = bus.sel_in;
            scnt_n = '0;
            st_n   = S_SETTLE;
          end
        end else if (dcnt == DW_LAST) begin
          wd_n = 1'b1;
          if (cur_sel == SEL_LAST) begin
            sd_n  = 1'b1;
            sel_n = '0;
            st_n  = S_IDLE;
          end else begin
            sel_n  = cur_sel + 1'b1;
            scnt_n = '0;
            st_n   = S_SETTLE;
          end
        end else begin
          dcnt_n = dcnt + 16'd1;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  // rst_n in the gate keeps ro_out low before the first reset edge lands
  assign bus.ro_out      = bus.ro_in[cur_sel] & valid & rst_n;
  assign bus.cur_sel     = cur_sel;
  assign bus.valid       = valid;
  assign bus.window_done = wdone;
  assign bus.scan_done   = sdone;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_ro_mux_seq.sv
// Bench for ro_mux_seq: timeline model (outputs as a function of cycles since the
// last select event) checked every cycle, plus directed literal checkpoints.
module tb_ro_mux_seq;
  localparam int N   = 16;
  localparam int S   = 4;
  localparam int D   = 8;
  localparam int P   = S + D;
  localparam int TOT = N * P;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ro_mux_seq_if #(.N_CH(N)) bus();
  ro_mux_seq #(.N_CH(N), .SETTLE(S), .DWELL(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- timeline model: op 0=idle 1=manual 2=scan, t0 = first settle cycle
  int m_op  = 0;
  int m_t0  = 0;
  int m_sel = 0;
  int cyc   = 0;
  int ep, e, x_sel;
  int x_busy, x_valid, x_wd, x_sd, x_ro;

  always @(posedge clk) begin
    ep = cyc - m_t0;
    if (m_op == 2 && ep >= TOT) begin m_op = 0; m_sel = 0; end
    if (!rst_n) begin
      m_op = 0; m_sel = 0;
    end else if (m_op == 0) begin
      if (!bus.stop) begin
        if (!bus.mode && bus.sel_load) begin
          m_op = 1; m_t0 = cyc + 1; m_sel = int'(bus.sel_in);
        end else if (bus.mode && bus.start) begin
          m_op = 2; m_t0 = cyc + 1;
        end
      end
    end else if (bus.stop) begin
      if (m_op == 2) m_sel = ep / P;
      m_op = 0;
    end else if (m_op == 1 && bus.sel_load && ep >= S) begin
      m_t0 = cyc + 1; m_sel = int'(bus.sel_in);
    end
    cyc++;
    #1;
    e = cyc - m_t0;
    x_busy = 0; x_valid = 0; x_wd = 0; x_sd = 0; x_sel = m_sel;
    if (m_op == 1) begin
      x_busy = 1; x_valid = (e >= S) ? 1 : 0;
    end else if (m_op == 2) begin
      if (e < TOT) begin
        x_busy  = 1;
        x_sel   = e / P;
        x_valid = ((e % P) >= S) ? 1 : 0;
        x_wd    = (e > 0 && (e % P) == 0) ? 1 : 0;
      end else begin
        x_sel = 0; x_wd = 1; x_sd = 1;
      end
    end
    x_ro = (x_valid != 0 && bus.ro_in[x_sel] && rst_n) ? 1 : 0;
    chk("m_busy",  int'(bus.busy),        x_busy);
    chk("m_valid", int'(bus.valid),       x_valid);
    chk("m_sel",   int'(bus.cur_sel),     x_sel);
    chk("m_wdone", int'(bus.window_done), x_wd);
    chk("m_sdone", int'(bus.scan_done),   x_sd);
    chk("m_roout", int'(bus.ro_out),      x_ro);
  end

  // oscillator inputs change mid-cycle, away from both sampling points
  initial begin
    bus.ro_in = '0;
    forever begin
      @(posedge clk);
      #3 bus.ro_in = N'($urandom);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int v);
    bus.sel_in   = 4'(v);
    bus.sel_load = 1'b1;
    tick(1);
    bus.sel_load = 1'b0;
  endtask

  int nwd, gap_bad, lastwd, sd_at, wd_seen;

  initial begin
    rst_n = 1'b0;
    bus.mode = 1'b0; bus.sel_in = '0; bus.sel_load = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    tick(2);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_sel",   int'(bus.cur_sel), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_roout", int'(bus.ro_out), 0);
    rst_n = 1'b1;
    tick(2);

    // manual load of channel 9
    load(9);
    chk("man_busy1",   int'(bus.busy), 1);
    chk("man_settle0", int'(bus.valid), 0);
    tick(3);
    chk("man_settle3", int'(bus.valid), 0);
    tick(1);
    chk("man_valid",   int'(bus.valid), 1);
    chk("man_sel9",    int'(bus.cur_sel), 9);
    repeat (4) begin
      tick(1);
      chk("man_track9", int'(bus.ro_out), int'(bus.ro_in[9]));
    end

    // reselect the same channel: gate drops for a full settle
    load(3);
    tick(4);
    chk("same_valid_pre", int'(bus.valid), 1);
    chk("same_sel3",      int'(bus.cur_sel), 3);
    load(3);
    chk("same_drop0", int'(bus.valid), 0);
    tick(3);
    chk("same_drop3", int'(bus.valid), 0);
    tick(1);
    chk("same_back",  int'(bus.valid), 1);

    // reset mid-MEASURE on channel 12
    load(12);
    tick(6);
    chk("rmid_sel12", int'(bus.cur_sel), 12);
    rst_n = 1'b0;
    tick(1);
    chk("rmid_busy",  int'(bus.busy), 0);
    chk("rmid_valid", int'(bus.valid), 0);
    chk("rmid_sel",   int'(bus.cur_sel), 0);
    chk("rmid_roout", int'(bus.ro_out), 0);
    rst_n = 1'b1;
    tick(1);

    // stop with sel_load in IDLE, then stop with start in IDLE
    bus.stop = 1'b1; bus.sel_in = 4'd6; bus.sel_load = 1'b1;
    tick(1);
    bus.stop = 1'b0; bus.sel_load = 1'b0;
    chk("stopload_idle", int'(bus.busy), 0);
    tick(2);
    chk("stopload_idle2", int'(bus.busy), 0);
    bus.mode = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("stopstart_idle", int'(bus.busy), 0);

    // full scan with ignored requests injected mid-pass
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    nwd = 0; gap_bad = 0; lastwd = 0; sd_at = -1;
    for (int i = 1; i <= TOT + 20 && sd_at < 0; i++) begin
      tick(1);
      if (bus.window_done) begin
        nwd++;
        if (i - lastwd != P) gap_bad++;
        lastwd = i;
      end
      if (bus.scan_done) begin
        sd_at = i;
        chk("scan_end_busy", int'(bus.busy), 0);
        chk("scan_end_sel",  int'(bus.cur_sel), 0);
        chk("scan_end_wd",   int'(bus.window_done), 1);
      end
      if (i == 20) begin
        bus.sel_in = 4'd7; bus.sel_load = 1'b1; bus.mode = 1'b0; bus.start = 1'b1;
      end else if (i == 21) begin
        bus.sel_load = 1'b0; bus.mode = 1'b1; bus.start = 1'b0;
      end
    end
    chk("scan_wd_count", nwd, 16);
    chk("scan_gaps",     gap_bad, 0);
    chk("scan_done_at",  sd_at, TOT);

    // stop mid-dwell on channel 5
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(5 * P + S + 3);
    chk("stop_pre_sel5",  int'(bus.cur_sel), 5);
    chk("stop_pre_valid", int'(bus.valid), 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("stop_busy",  int'(bus.busy), 0);
    chk("stop_valid", int'(bus.valid), 0);
    chk("stop_sel5",  int'(bus.cur_sel), 5);
    wd_seen = 0;
    repeat (P) begin
      if (bus.window_done) wd_seen++;
      tick(1);
    end
    chk("stop_no_wd", wd_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
